// File: rtl/commit_trace_checker.sv
// commit_trace_checker
// Compares the commit stream of a fault-injected core against the golden core.
// Golden commits are buffered so the faulty core may lag by up to DEPTH
// commits; the first divergence is latched and the run ends in DONE, HALT
// (mismatch) or ERROR (overflow / desync).
module commit_trace_checker #(
   parameter int DEPTH        = 8,
   parameter int MAX_COMPARES = 1024
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     g_valid,
   input  logic [31:0]              g_pc,
   input  logic [31:0]              g_result,
   input  logic                     f_valid,
   input  logic [31:0]              f_pc,
   input  logic [31:0]              f_result,
   output logic                     busy,
   output logic                     done,
   output logic                     mismatch,
   output logic                     error,
   output logic [15:0]              fail_index,
   output logic [31:0]              fail_pc,
   output logic [31:0]              fail_exp,
   output logic [31:0]              fail_act,
   output logic [15:0]              compare_count,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
   localparam logic [15:0] CMP_LAST = 16'(MAX_COMPARES);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_DONE  = 3'd2,
      S_HALT  = 3'd3,
      S_ERROR = 3'd4
   } state_t;

   state_t        r_state;
   logic [63:0]   r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic [15:0]   r_count;
   logic          r_busy;
   logic          r_done;
   logic          r_mismatch;
   logic          r_error;
   logic [15:0]   r_fail_index;
   logic [31:0]   r_fail_pc;
   logic [31:0]   r_fail_exp;
   logic [31:0]   r_fail_act;

   logic          w_run;
   logic          w_empty;
   logic          w_full;
   logic          w_desync;
   logic          w_overflow;
   logic          w_cmp;
   logic          w_bypass;
   logic          w_push;
   logic          w_pop;
   logic [63:0]   w_exp;
   logic          w_hit;
   logic [15:0]   w_count_inc;
   logic          w_last;

   // Push/compare decode for the current cycle. The head is read
   // asynchronously so a compare never needs a wait state; when the FIFO is
   // empty the golden commit of this very cycle is the expected value.
   always_comb begin
      w_run       = (r_state == S_RUN);
      w_empty     = (r_level == '0);
      w_full      = (r_level == LVL_FULL);
      w_desync    = f_valid && w_empty && !g_valid;
      w_overflow  = g_valid && w_full && !f_valid;
      w_cmp       = w_run && !w_desync && !w_overflow && f_valid;
      w_bypass    = w_empty && g_valid && f_valid;
      w_push      = w_run && !w_desync && !w_overflow && g_valid && !w_bypass;
      w_pop       = w_cmp && !w_empty;
      w_exp       = w_empty ? {g_pc, g_result} : r_mem[r_rd_ptr];
      w_hit       = (w_exp == {f_pc, f_result});
      w_count_inc = r_count + 16'd1;
      w_last      = (w_count_inc == CMP_LAST);
   end

   // Golden FIFO storage; contents need no reset because level gates reads.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {g_pc, g_result};
      end
   end

   // Run-control FSM with FIFO pointers, counters and latched failure info.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_level      <= '0;
         r_count      <= '0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_mismatch   <= 1'b0;
         r_error      <= 1'b0;
         r_fail_index <= '0;
         r_fail_pc    <= '0;
         r_fail_exp   <= '0;
         r_fail_act   <= '0;
      end else begin
         case (r_state)
            S_RUN: begin
               if (w_desync || w_overflow) begin
                  r_state <= S_ERROR;
                  r_error <= 1'b1;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end else begin
                  if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                  if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                  // A simultaneous push and pop leaves occupancy unchanged.
                  if (w_push && !w_pop)      r_level <= r_level + 1'b1;
                  else if (w_pop && !w_push) r_level <= r_level - 1'b1;
                  if (w_cmp) begin
                     r_count <= w_count_inc;
                     if (!w_hit) begin
                        r_state      <= S_HALT;
                        r_mismatch   <= 1'b1;
                        r_fail_index <= r_count;
                        r_fail_pc    <= w_exp[63:32];
                        r_fail_exp   <= w_exp[31:0];
                        r_fail_act   <= f_result;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                     end else if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end
                  end
               end
            end
            default: begin
               // IDLE, DONE, HALT and ERROR hold everything until start.
               if (start) begin
                  r_state      <= S_RUN;
                  r_wr_ptr     <= '0;
                  r_rd_ptr     <= '0;
                  r_level      <= '0;
                  r_count      <= '0;
                  r_busy       <= 1'b1;
                  r_done       <= 1'b0;
                  r_mismatch   <= 1'b0;
                  r_error      <= 1'b0;
                  r_fail_index <= '0;
                  r_fail_pc    <= '0;
                  r_fail_exp   <= '0;
                  r_fail_act   <= '0;
               end
            end
         endcase
      end
   end

   assign busy          = r_busy;
   assign done          = r_done;
   assign mismatch      = r_mismatch;
   assign error         = r_error;
   assign fail_index    = r_fail_index;
   assign fail_pc       = r_fail_pc;
   assign fail_exp      = r_fail_exp;
   assign fail_act      = r_fail_act;
   assign compare_count = r_count;
   assign level         = r_level;

endmodule

// File: tb/tb_commit_trace_checker.sv
// Testbench for commit_trace_checker: directed scenarios followed by random
// commit streams, all checked every cycle against a queue-based model.
module tb_commit_trace_checker;

   localparam int DEPTH = 8;
   localparam int MAXC  = 16;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_DONE  = 2;
   localparam int M_HALT  = 3;
   localparam int M_ERROR = 4;

   logic        clk = 1'b0;
   logic        rst, start, g_valid, f_valid;
   logic [31:0] g_pc, g_result, f_pc, f_result;
   logic        busy, done, mismatch, error;
   logic [15:0] fail_index, compare_count;
   logic [31:0] fail_pc, fail_exp, fail_act;
   logic [3:0]  level;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state.
   int          m_state;
   logic [63:0] m_q[$];
   int          m_cnt;
   logic        m_mis, m_err;
   int          m_fidx;
   logic [31:0] m_fpc, m_fexp, m_fact;

   // Random driver's record of golden commits not yet replayed by the faulty core.
   logic [63:0] pend[$];

   commit_trace_checker #(.DEPTH(DEPTH), .MAX_COMPARES(MAXC)) dut (
      .clk(clk), .rst(rst), .start(start),
      .g_valid(g_valid), .g_pc(g_pc), .g_result(g_result),
      .f_valid(f_valid), .f_pc(f_pc), .f_result(f_result),
      .busy(busy), .done(done), .mismatch(mismatch), .error(error),
      .fail_index(fail_index), .fail_pc(fail_pc), .fail_exp(fail_exp),
      .fail_act(fail_act), .compare_count(compare_count), .level(level)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_q.delete();
      m_cnt = 0; m_mis = 0; m_err = 0;
      m_fidx = 0; m_fpc = 0; m_fexp = 0; m_fact = 0;
   endtask

   // One clock edge of the intended behaviour, written in queue terms.
   task automatic model_step(input logic gv, input logic [31:0] gp, gr,
                             input logic fv, input logic [31:0] fp, fr,
                             input logic st, rs);
      logic [63:0] e;
      if (rs) begin
         m_state = M_IDLE;
         model_clear();
      end else if (m_state != M_RUN) begin
         if (st) begin
            m_state = M_RUN;
            model_clear();
         end
      end else if (fv && !gv && m_q.size() == 0) begin
         m_state = M_ERROR; m_err = 1;
      end else if (gv && !fv && m_q.size() == DEPTH) begin
         m_state = M_ERROR; m_err = 1;
      end else begin
         if (gv) m_q.push_back({gp, gr});
         if (fv) begin
            e = m_q.pop_front();
            if (e != {fp, fr}) begin
               m_mis = 1; m_fidx = m_cnt; m_fpc = e[63:32];
               m_fexp = e[31:0]; m_fact = fr;
               m_state = M_HALT;
            end
            m_cnt++;
            if (!m_mis && m_cnt == MAXC) m_state = M_DONE;
         end
      end
   endtask

   task automatic compare_all();
      check("busy", busy, m_state == M_RUN);
      check("done", done, m_state >= M_DONE);
      check("mismatch", mismatch, m_mis);
      check("error", error, m_err);
      check("fail_index", fail_index, m_fidx);
      check("fail_pc", fail_pc, m_fpc);
      check("fail_exp", fail_exp, m_fexp);
      check("fail_act", fail_act, m_fact);
      check("compare_count", compare_count, m_cnt);
      check("level", level, m_q.size());
   endtask

   task automatic cycle(input logic gv, input logic [31:0] gp, gr,
                        input logic fv, input logic [31:0] fp, fr,
                        input logic st, rs);
      g_valid = gv; g_pc = gp; g_result = gr;
      f_valid = fv; f_pc = fp; f_result = fr;
      start = st; rst = rs;
      @(posedge clk);
      model_step(gv, gp, gr, fv, fp, fr, st, rs);
      #1;
      compare_all();
   endtask

   task automatic idle_start();
      cycle(0, 0, 0, 0, 0, 0, 1, 0);
   endtask

   // Lockstep run of n commits, PC = 4*i, result = PC unless i == bad_idx.
   task automatic lockstep(input int n, input int bad_idx);
      for (int i = 0; i < n; i++) begin
         logic [31:0] pc;
         pc = 32'(i * 4);
         cycle(1, pc, pc, 1, pc, (i == bad_idx) ? pc + 1 : pc, 0, 0);
      end
   endtask

   initial begin
      logic        gv, fv, st, rs;
      logic [31:0] gp, gr, fp, fr;
      logic [63:0] e;

      m_state = M_IDLE;
      model_clear();

      // Reset state.
      cycle(0, 0, 0, 0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 0, 0, 0, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      // Inputs ignored in IDLE.
      cycle(1, 32'h10, 32'h20, 1, 32'h10, 32'h21, 0, 0);
      check("idle_ignored_level", level, 0);

      // Clean lockstep run.
      idle_start();
      check("t1_busy", busy, 1);
      lockstep(16, -1);
      check("t1_done", done, 1);
      check("t1_mismatch", mismatch, 0);
      check("t1_count", compare_count, 16);

      // Faulty stream lagging by 3 commits.
      idle_start();
      for (int i = 0; i < 19; i++) begin
         gv = (i < 16);
         fv = (i >= 3);
         gp = 32'(i * 4);
         fp = 32'((i - 3) * 4);
         cycle(gv, gp, gp ^ 32'hA5A5_0000, fv, fp, fp ^ 32'hA5A5_0000, 0, 0);
         if (i == 10) check("t2_level", level, 3);
      end
      check("t2_done", done, 1);
      check("t2_mismatch", mismatch, 0);

      // Mismatch at compare index 5.
      idle_start();
      lockstep(6, 5);
      check("t3_mismatch", mismatch, 1);
      check("t3_fail_index", fail_index, 5);
      check("t3_fail_pc", fail_pc, 32'h14);
      check("t3_fail_exp", fail_exp, 32'h14);
      check("t3_fail_act", fail_act, 32'h15);
      check("t3_count", compare_count, 6);
      check("t3_done", done, 1);
      // HALT holds everything.
      lockstep(3, -1);
      check("t3_hold_count", compare_count, 6);

      // Overflow.
      idle_start();
      for (int i = 0; i < 9; i++) begin
         cycle(1, 32'(i * 4), 32'(i), 0, 0, 0, 0, 0);
         if (i == 7) check("t4_level8", level, 8);
      end
      check("t4_error", error, 1);
      check("t4_done", done, 1);
      check("t4_level", level, 8);

      // Desync, then restart.
      idle_start();
      cycle(0, 0, 0, 1, 32'h4, 32'h4, 0, 0);
      check("t5_error", error, 1);
      idle_start();
      check("t5_busy", busy, 1);
      check("t5_error_clr", error, 0);
      check("t5_count", compare_count, 0);

      // Reset mid-run with data buffered, then a clean run.
      for (int i = 0; i < 4; i++) cycle(1, 32'(i * 4), 32'(i), 0, 0, 0, 0, 0);
      check("t6_level4", level, 4);
      cycle(0, 0, 0, 0, 0, 0, 1, 1);
      check("t6_busy", busy, 0);
      check("t6_level", level, 0);
      idle_start();
      lockstep(16, -1);
      check("t6_done", done, 1);
      check("t6_mismatch", mismatch, 0);

      // Random streams.
      pend.delete();
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            pend.delete();
            cycle(0, 0, 0, 0, 0, 0, 1, 1);
         end else if (m_state != M_RUN) begin
            pend.delete();
            cycle($urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 1),
                  $urandom, $urandom, 1, 0);
         end else begin
            gv = ($urandom_range(0, 99) < 55);
            gp = $urandom; gr = $urandom;
            fv = ($urandom_range(0, 99) < 50) && (pend.size() > 0 || gv);
            if ($urandom_range(0, 99) < 2) fv = 1'b1;
            st = ($urandom_range(0, 19) == 0);
            rs = 1'b0;
            if (gv) pend.push_back({gp, gr});
            fp = $urandom; fr = $urandom;
            if (fv && pend.size() > 0) begin
               e = pend.pop_front();
               fp = e[63:32]; fr = e[31:0];
               if ($urandom_range(0, 99) < 3) fr = fr ^ (32'h1 << $urandom_range(0, 31));
               if ($urandom_range(0, 199) == 0) fp = fp ^ 32'h4;
            end
            cycle(gv, gp, gr, fv, fp, fr, st, rs);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/commit_trace_checker.md
# commit_trace_checker

Consumes the per-cycle commit stream (PC, writeback result) of the golden single-cycle core and of a fault-injected copy of it. It buffers golden commits in a small FIFO so the faulty core may lag by up to DEPTH commits, and compares entries in order. It latches the first divergence and reports run completion. It sits beside the two core instances in the fault-simulation harness as the reader of their commit-trace outputs.

## Interface
Parameters:
- DEPTH, 8: golden FIFO entries; power of two, ≥2.
- MAX_COMPARES, 1024: compares per run before a clean DONE; 1..65535.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  begin a run; honoured in IDLE, DONE, HALT, ERROR.
- g_valid  in  1  golden commit present this cycle.
- g_pc  in  32  golden commit PC.
- g_result  in  32  golden writeback result.
- f_valid  in  1  faulty commit present this cycle.
- f_pc  in  32  faulty commit PC.
- f_result  in  32  faulty writeback result.
- busy  out  1  state is RUN.
- done  out  1  state is DONE, HALT or ERROR.
- mismatch  out  1  sticky; first divergence found.
- error  out  1  sticky; FIFO overflow or desync.
- fail_index  out  16  compare index (0-based) of first mismatch.
- fail_pc  out  32  golden PC at first mismatch.
- fail_exp  out  32  golden result at first mismatch.
- fail_act  out  32  faulty result at first mismatch.
- compare_count  out  16  compares completed this run.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- States: IDLE, RUN, DONE, HALT, ERROR.
- IDLE: inputs ignored. start → RUN.
- Entering RUN from any state clears the FIFO, compare_count, mismatch, error and all fail_* outputs.
- RUN push: g_valid pushes {g_pc, g_result}.
- RUN compare: f_valid pops the head and compares it with {f_pc, f_result}. Match requires both 32-bit fields equal.
- Bypass: when the FIFO is empty and g_valid and f_valid arrive in the same cycle, f_* is compared directly against g_*. Nothing is stored and level stays 0.
- Full with a pop in the same cycle: the push is accepted and level is unchanged.
- Overflow: g_valid while full with no pop → ERROR, error=1, nothing stored.
- Desync: f_valid while empty with no g_valid → ERROR, error=1.
- Each compare increments compare_count. The compare's index is the pre-increment value.
- On a mismatch:
  - fail_index, fail_pc, fail_exp and fail_act are captured.
  - mismatch=1 and the state goes to HALT.
  - Mismatch takes priority over reaching MAX_COMPARES on the same compare.
- When compare_count reaches MAX_COMPARES with no mismatch → DONE.
- DONE, HALT and ERROR: all push and compare activity stops and every output holds. start → RUN.
- start asserted while in RUN is ignored.

## Timing
- All outputs are registered and update on the clk edge that samples the triggering inputs.
- A compare sampled at edge N is visible in compare_count, mismatch and fail_* after edge N.
- busy/done change after the same edge.
- Throughput: one push and one compare per cycle, sustained. No wait states.
- Latency from f_valid sampling to a visible mismatch: 1 cycle.
- Reset (rst=1 at an edge, any state, including mid-run with data buffered):
  - state=IDLE, FIFO emptied.
  - busy, done, mismatch and error are 0.
  - fail_* are 0, compare_count=0, level=0.
  - rst takes priority over start.
- Pointers wrap modulo DEPTH. level distinguishes full (DEPTH) from empty (0).

## Test plan
- Lockstep identical streams, MAX_COMPARES=16, PC 0x0..0x3C step 4 → done=1 after the 16th compare, mismatch=0, compare_count=16, level=0 throughout.
- Faulty stream delayed 3 cycles, identical data → level holds at 3 in steady state, no mismatch, clean DONE.
- Both streams identical except at compare index 5 (PC 0x14): golden result 0x00000014, faulty 0x00000015 → mismatch=1, fail_index=5, fail_pc=0x14, fail_exp=0x14, fail_act=0x15, state HALT, compare_count=6.
- DEPTH=8, f_valid held low, 9 consecutive g_valid → level=8 after the 8th; after the 9th, error=1, done=1, level stays 8.
- f_valid=1 with the FIFO empty and g_valid=0 → error=1 next cycle. Then start → busy=1, error=0, compare_count=0.
- rst asserted in RUN with level=4 → next cycle all outputs 0, state IDLE. A subsequent start with lockstep streams completes a clean run.
